// File: rtl/regfile_pkg.sv
// Shared parameters for the integer register file and its scoreboard.
// Address-width helper and the hardwired-zero register index.
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

  function automatic int addr_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write busy bits with issue-set / writeback-clear and a sticky
// error flag for retires that find no outstanding producer.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int NRD   = 2,
  parameter int NWR   = 2,
  parameter int AW    = addr_w(NREGS_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR-1:0]    wr_clr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREGS-1:0]  busy_vec,
  output logic              sb_err
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;
  logic [NREGS-1:0] busy_nxt;
  logic             err_hit;

  // Per-register set/clear requests for this cycle; register 0 never tracked
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_en) set_v[iss_addr] = 1'b1;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j]) clr_v[wr_addr[j*AW +: AW]] = 1'b1;
    end
    set_v[ZERO_REG] = 1'b0;
    clr_v[ZERO_REG] = 1'b0;
  end

  // Retire with no outstanding producer and no same-cycle issue is an error
  always_comb begin
    err_hit = 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j]
          && wr_addr[j*AW +: AW] != AW'(ZERO_REG)
          && !busy[wr_addr[j*AW +: AW]]
          && !set_v[wr_addr[j*AW +: AW]]) err_hit = 1'b1;
    end
  end

  // Set dominates clear: a new producer supersedes the retiring one
  always_comb begin
    busy_nxt = (busy & ~clr_v) | set_v;
    busy_nxt[ZERO_REG] = 1'b0;
  end

  // Busy bits and sticky error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy   <= '0;
      sb_err <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      sb_err <= sb_err | err_hit;
    end
  end

  // Hazard flags: a same-cycle retiring write bypasses the hazard
  always_comb begin
    rd_busy = '0;
    for (int i = 0; i < NRD; i++) begin
      rd_busy[i] = busy[rd_addr[i*AW +: AW]]
                 & ~clr_v[rd_addr[i*AW +: AW]];
    end
  end

  assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-first bypass, hardwired
// zero register and an integrated pending-write scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = NREGS_DEF,
  parameter  int NRD   = 2,
  parameter  int NWR   = 2,
  localparam int AW    = addr_w(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic [NWR-1:0]      wr_clr,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREGS-1:0]    busy_vec,
  output logic                sb_err
);

  logic [XLEN-1:0] mem [NREGS];
  logic [AW-1:0]   wa  [NWR];
  logic [XLEN-1:0] wd  [NWR];
  logic [NWR-1:0]  we;

  for (genvar j = 0; j < NWR; j++) begin : g_wr
    assign wa[j] = wr_addr[j*AW +: AW];
    assign wd[j] = wr_data[j*XLEN +: XLEN];
    assign we[j] = wr_en[j] && (wa[j] != AW'(ZERO_REG));
  end

  // Data array; later ports overwrite earlier ones on address collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) mem[r] <= '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (we[j]) mem[wa[j]] <= wd[j];
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    assign a = rd_addr[i*AW +: AW];

    // Write-first bypass, highest write port wins, zero register forced
    always_comb begin
      d = mem[a];
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && wa[j] == a) d = wd[j];
      end
      if (a == AW'(ZERO_REG)) d = '0;
    end

    assign rd_data[i*XLEN +: XLEN] = d;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR),
    .AW    (AW)
  ) u_sb (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .sb_err   (sb_err)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Randomized and directed bench for regfile_mp_sb against an
// array-based reference model of the register file and scoreboard.
module tb_regfile_mp_sb;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;

  logic [AW-1:0]   ra [NRD];
  logic [AW-1:0]   wa [NWR];
  logic [XLEN-1:0] wd [NWR];
  logic [NWR-1:0]  wr_en;
  logic [NWR-1:0]  wr_clr;
  logic            iss_en;
  logic [AW-1:0]   iss_addr;

  logic [NRD*AW-1:0]   rd_addr;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NREGS-1:0]    busy_vec;
  logic                sb_err;

  assign rd_addr = {ra[1], ra[0]};
  assign wr_addr = {wa[1], wa[0]};
  assign wr_data = {wd[1], wd[0]};

  regfile_mp_sb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_clr   (wr_clr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .sb_err   (sb_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_busy [NREGS];
  bit              m_err;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int r = 0; r < NREGS; r++) begin
      m_mem[r]  = '0;
      m_busy[r] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int j = NWR - 1; j >= 0; j--) begin
      if (wr_en[j] && wa[j] == a) return wd[j];
    end
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j] && wa[j] == a) return 1'b0;
    end
    return m_busy[a];
  endfunction

  task automatic model_edge();
    bit setv [NREGS];
    bit clrv [NREGS];
    for (int r = 0; r < NREGS; r++) begin
      setv[r] = 1'b0;
      clrv[r] = 1'b0;
    end
    if (iss_en && iss_addr != 0) setv[iss_addr] = 1'b1;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j] && wa[j] != 0) begin
        clrv[wa[j]] = 1'b1;
        if (!m_busy[wa[j]] && !setv[wa[j]]) m_err = 1'b1;
      end
    end
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wa[j] != 0) m_mem[wa[j]] = wd[j];
    end
    for (int r = 1; r < NREGS; r++) begin
      if (setv[r]) m_busy[r] = 1'b1;
      else if (clrv[r]) m_busy[r] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic [NREGS-1:0] v;
    for (int r = 0; r < NREGS; r++) v[r] = m_busy[r];
    for (int i = 0; i < NRD; i++) begin
      check($sformatf("rd_data%0d", i), 64'(rd_data[i*XLEN +: XLEN]),
            64'(exp_rd(ra[i])));
      check($sformatf("rd_busy%0d", i), 64'(rd_busy[i]),
            64'(exp_busy(ra[i])));
    end
    check("busy_vec", 64'(busy_vec), 64'(v));
    check("sb_err", 64'(sb_err), 64'(m_err));
  endtask

  task automatic idle();
    for (int i = 0; i < NRD; i++) ra[i] = '0;
    for (int j = 0; j < NWR; j++) begin
      wa[j] = '0;
      wd[j] = '0;
    end
    wr_en    = '0;
    wr_clr   = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  task automatic rand_in(input bit narrow);
    for (int i = 0; i < NRD; i++)
      ra[i] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
    for (int j = 0; j < NWR; j++) begin
      wa[j] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wd[j] = $urandom;
    end
    wr_en    = NWR'($urandom);
    wr_clr   = NWR'($urandom);
    iss_en   = 1'($urandom);
    iss_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom);
  endtask

  // Inputs are set just after a falling edge; check, clock, update model
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
  endtask

  task automatic mid_reset();
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check("rst_busy_vec", 64'(busy_vec), 64'(0));
    check("rst_sb_err", 64'(sb_err), 64'(0));
    wr_en = '0;
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    model_clear();
    rand_in(1'b0);
    @(negedge clk);
    step();
    rand_in(1'b1);
    step();
    idle();
    @(negedge clk);
    reset = 1'b0;

    // all addresses read zero after reset
    for (int k = 0; k < NREGS / 2; k++) begin
      ra[0] = AW'(2 * k);
      ra[1] = AW'(2 * k + 1);
      step();
    end
    #1;
    check("t1_busy_vec", 64'(busy_vec), 64'(0));

    // bypass then stored
    idle();
    wr_en = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[0] = 5;
    #1;
    check("t2_bypass", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
    step();
    idle(); ra[0] = 5;
    #1;
    check("t2_stored", 64'(rd_data[31:0]), 64'h0000_0000_DEAD_BEEF);
    step();

    // write collision, highest port wins; zero register discards
    idle();
    wr_en = 2'b11; wa[0] = 7; wa[1] = 7; wd[0] = 32'h11; wd[1] = 32'h22;
    ra[1] = 7;
    #1;
    check("t3_coll_byp", 64'(rd_data[63:32]), 64'h22);
    step();
    idle(); ra[0] = 7; wr_en = 2'b01; wa[0] = 0; wd[0] = 32'h33; ra[1] = 0;
    #1;
    check("t3_coll_st", 64'(rd_data[31:0]), 64'h22);
    check("t3_zero", 64'(rd_data[63:32]), 64'h0);
    step();

    // issue then retire
    idle(); iss_en = 1'b1; iss_addr = 3;
    step();
    idle(); ra[0] = 3;
    #1;
    check("t4_busy_vec3", 64'(busy_vec[3]), 64'h1);
    check("t4_rd_busy", 64'(rd_busy[0]), 64'h1);
    step();
    idle(); ra[0] = 3; wr_en = 2'b01; wr_clr = 2'b01; wa[0] = 3;
    wd[0] = 32'h99;
    #1;
    check("t4_rd_busy_byp", 64'(rd_busy[0]), 64'h0);
    check("t4_rd_data", 64'(rd_data[31:0]), 64'h99);
    step();
    idle();
    #1;
    check("t4_clr", 64'(busy_vec[3]), 64'h0);

    // same-cycle issue and retire: set wins
    idle(); iss_en = 1'b1; iss_addr = 4;
    step();
    idle(); iss_en = 1'b1; iss_addr = 4; wr_en = 2'b10; wr_clr = 2'b10;
    wa[1] = 4; wd[1] = 32'h44;
    step();
    idle();
    #1;
    check("t5_busy4", 64'(busy_vec[4]), 64'h1);
    check("t5_err", 64'(sb_err), 64'h0);

    // retire to idle register is sticky error
    idle(); wr_en = 2'b01; wr_clr = 2'b01; wa[0] = 9; wd[0] = 32'h9;
    step();
    for (int k = 0; k < 6; k++) begin
      rand_in(1'b1);
      step();
    end
    #1;
    check("t6_err_sticky", 64'(sb_err), 64'h1);
    ra[0] = 9; wr_en = '0;
    mid_reset();
    idle(); ra[0] = 9; ra[1] = 4;
    step();

    // randomized traffic with occasional asynchronous reset
    for (int k = 0; k < 600; k++) begin
      rand_in(($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 120) == 0) mid_reset();
      else step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
